// File: rtl/vga_fill_arbiter_pkg.sv
// Shared video definitions: geometry defaults, RGB color encodings and fill FSM states.
package vga_fill_arbiter_pkg;

  localparam int COL_W_DEF   = 8;
  localparam int ROW_W_DEF   = 8;
  localparam int COLOR_W_DEF = 3;

  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_e;

endpackage

// File: rtl/vga_fill_arbiter_scan.sv
// Row-major col/row scan counter with load, hold and end-of-rectangle detect.
module vga_scan_counter
  import vga_fill_arbiter_pkg::*;
#(
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [COL_W-1:0] ld_col_i,
  input  logic [ROW_W-1:0] ld_row_i,
  input  logic [COL_W-1:0] x0_i,
  input  logic [COL_W-1:0] x1_i,
  input  logic [ROW_W-1:0] y1_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             row_end;

  // End tests compare against the bounds before incrementing, so 255 never wraps.
  assign row_end = (col_q == x1_i);
  assign last_o  = row_end && (row_q == y1_i);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (load_i) begin
      col_d = ld_col_i;
      row_d = ld_row_i;
    end else if (advance_i && !last_o) begin
      if (row_end) begin
        col_d = x0_i;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/vga_fill_arbiter.sv
// Video RAM write-port arbiter: CPU pixel writes take priority over the rectangle-fill engine.
module vga_fill_arbiter
  import vga_fill_arbiter_pkg::*;
#(
  parameter int COL_W   = COL_W_DEF,
  parameter int ROW_W   = ROW_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iCpuWe,
  input  logic [COL_W-1:0]       iCpuCol,
  input  logic [ROW_W-1:0]       iCpuRow,
  input  logic [COLOR_W-1:0]     iCpuColor,
  input  logic                   iFillStart,
  input  logic                   iFillAbort,
  input  logic [COL_W-1:0]       iX0,
  input  logic [COL_W-1:0]       iX1,
  input  logic [ROW_W-1:0]       iY0,
  input  logic [ROW_W-1:0]       iY1,
  input  logic [COLOR_W-1:0]     iFillColor,
  output logic                   oFillBusy,
  output logic                   oFillDone,
  output logic                   oFillError,
  output logic                   oRamWe,
  output logic [ROW_W+COL_W-1:0] oRamAddr,
  output logic [COLOR_W-1:0]     oRamData
);

  fill_state_e state_q, state_d;

  logic [COL_W-1:0]       x0_q, x0_d, x1_q, x1_d;
  logic [ROW_W-1:0]       y1_q, y1_d;
  logic [COLOR_W-1:0]     color_q, color_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                   we_q, we_d;
  logic [ROW_W+COL_W-1:0] addr_q, addr_d;
  logic [COLOR_W-1:0]     data_q, data_d;

  logic             scan_load, scan_adv, scan_last;
  logic [COL_W-1:0] scan_col;
  logic [ROW_W-1:0] scan_row;

  vga_scan_counter #(
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_scan (
    .Clock    (Clock),
    .Reset    (Reset),
    .load_i   (scan_load),
    .advance_i(scan_adv),
    .ld_col_i (iX0),
    .ld_row_i (iY0),
    .x0_i     (x0_q),
    .x1_i     (x1_q),
    .y1_i     (y1_q),
    .col_o    (scan_col),
    .row_o    (scan_row),
    .last_o   (scan_last)
  );

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    color_d   = color_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    scan_load = 1'b0;
    scan_adv  = 1'b0;

    if (iCpuWe) begin
      we_d   = 1'b1;
      addr_d = {iCpuRow, iCpuCol};
      data_d = iCpuColor;
    end

    unique case (state_q)
      FILL_IDLE: begin
        if (iFillStart) begin
          if ((iX0 > iX1) || (iY0 > iY1)) begin
            err_d = 1'b1;
          end else begin
            x0_d      = iX0;
            x1_d      = iX1;
            y1_d      = iY1;
            color_d   = iFillColor;
            scan_load = 1'b1;
            state_d   = FILL_RUN;
          end
        end
      end
      FILL_RUN: begin
        if (iFillAbort) begin
          state_d = FILL_IDLE;
        end else if (iCpuWe) begin
          busy_d = 1'b1;  // CPU owns the port this cycle; scan position holds
        end else begin
          we_d   = 1'b1;
          addr_d = {scan_row, scan_col};
          data_d = color_q;
          if (scan_last) begin
            done_d  = 1'b1;
            state_d = FILL_IDLE;
          end else begin
            busy_d   = 1'b1;
            scan_adv = 1'b1;
          end
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= FILL_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign oFillBusy  = busy_q;
  assign oFillDone  = done_q;
  assign oFillError = err_q;
  assign oRamWe     = we_q;
  assign oRamAddr   = addr_q;
  assign oRamData   = data_q;

endmodule

// File: tb/tb_vga_fill_arbiter.sv
// Directed checks of the fill engine, CPU priority, error, abort and reset behaviour.
module tb_vga_fill_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iCpuWe = 1'b0;
  logic [7:0]  iCpuCol = '0, iCpuRow = '0;
  logic [2:0]  iCpuColor = '0;
  logic        iFillStart = 1'b0, iFillAbort = 1'b0;
  logic [7:0]  iX0 = '0, iX1 = '0, iY0 = '0, iY1 = '0;
  logic [2:0]  iFillColor = '0;
  logic        oFillBusy, oFillDone, oFillError, oRamWe;
  logic [15:0] oRamAddr;
  logic [2:0]  oRamData;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed addresses of the 4x2 fill at X 0..3, Y 0..1.
  logic [15:0] exp8 [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                            16'h0100, 16'h0101, 16'h0102, 16'h0103};

  vga_fill_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuWe(iCpuWe), .iCpuCol(iCpuCol), .iCpuRow(iCpuRow), .iCpuColor(iCpuColor),
    .iFillStart(iFillStart), .iFillAbort(iFillAbort),
    .iX0(iX0), .iX1(iX1), .iY0(iY0), .iY1(iY1), .iFillColor(iFillColor),
    .oFillBusy(oFillBusy), .oFillDone(oFillDone), .oFillError(oFillError),
    .oRamWe(oRamWe), .oRamAddr(oRamAddr), .oRamData(oRamData)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_rect(input logic [7:0] x0, input logic [7:0] x1,
                          input logic [7:0] y0, input logic [7:0] y1, input logic [2:0] c);
    iX0 = x0; iX1 = x1; iY0 = y0; iY1 = y1; iFillColor = c;
  endtask

  task automatic start_fill();
    iFillStart = 1'b1;
    step();
    iFillStart = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    check_val("rst_we", oRamWe, 0);
    check_val("rst_busy", oFillBusy, 0);
    check_val("rst_done", oFillDone, 0);
    check_val("rst_err", oFillError, 0);
    check_val("rst_addr", oRamAddr, 0);
    check_val("rst_data", oRamData, 0);
    Reset = 1'b1;
    step();

    // 8-pixel fill; a start with bad bounds during FILL must be ignored silently
    set_rect(8'd0, 8'd3, 8'd0, 8'd1, 3'b100);
    start_fill();
    iX0 = 8'd5; iX1 = 8'd4; iFillStart = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i >= 6) iFillStart = 1'b0;
      check_val($sformatf("f8_we%0d", i), oRamWe, 1);
      check_val($sformatf("f8_addr%0d", i), oRamAddr, exp8[i]);
      check_val($sformatf("f8_data%0d", i), oRamData, 3'b100);
      check_val($sformatf("f8_done%0d", i), oFillDone, (i == 7));
      check_val($sformatf("f8_busy%0d", i), oFillBusy, (i != 7));
      check_val($sformatf("f8_err%0d", i), oFillError, 0);
    end
    step();
    check_val("f8_idle_we", oRamWe, 0);
    check_val("f8_idle_busy", oFillBusy, 0);
    check_val("f8_idle_done", oFillDone, 0);

    // Single pixel at the top corner, no wrap
    set_rect(8'd255, 8'd255, 8'd255, 8'd255, 3'b010);
    start_fill();
    step();
    check_val("corner_we", oRamWe, 1);
    check_val("corner_addr", oRamAddr, 16'hFFFF);
    check_val("corner_data", oRamData, 3'b010);
    check_val("corner_done", oFillDone, 1);
    check_val("corner_busy", oFillBusy, 0);
    step();
    check_val("corner_after_we", oRamWe, 0);
    check_val("corner_after_done", oFillDone, 0);

    // 8-pixel fill with a CPU write when the 3rd pixel is due
    set_rect(8'd0, 8'd3, 8'd0, 8'd1, 3'b100);
    start_fill();
    step(); check_val("cpu_px0", oRamAddr, exp8[0]);
    step(); check_val("cpu_px1", oRamAddr, exp8[1]);
    iCpuWe = 1'b1; iCpuCol = 8'd10; iCpuRow = 8'd20; iCpuColor = 3'b001;
    step();
    iCpuWe = 1'b0;
    check_val("cpu_we", oRamWe, 1);
    check_val("cpu_addr", oRamAddr, 16'h140A);
    check_val("cpu_data", oRamData, 3'b001);
    check_val("cpu_busy", oFillBusy, 1);
    for (int i = 2; i < 8; i++) begin
      step();
      check_val($sformatf("cpu_px%0d_we", i), oRamWe, 1);
      check_val($sformatf("cpu_px%0d_addr", i), oRamAddr, exp8[i]);
      check_val($sformatf("cpu_px%0d_data", i), oRamData, 3'b100);
      check_val($sformatf("cpu_px%0d_done", i), oFillDone, (i == 7));
    end
    step();
    check_val("cpu_end_we", oRamWe, 0);

    // Rejected start
    set_rect(8'd5, 8'd4, 8'd0, 8'd0, 3'b111);
    start_fill();
    check_val("err_pulse", oFillError, 1);
    check_val("err_we", oRamWe, 0);
    check_val("err_busy", oFillBusy, 0);
    step();
    check_val("err_clear", oFillError, 0);
    check_val("err_we2", oRamWe, 0);
    check_val("err_busy2", oFillBusy, 0);

    // Abort a 16-pixel fill after 3 pixels; simultaneous start is dropped
    set_rect(8'd0, 8'd3, 8'd0, 8'd3, 3'b011);
    start_fill();
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("ab_px%0d", i), oRamAddr, exp8[i]);
      check_val($sformatf("ab_we%0d", i), oRamWe, 1);
    end
    iFillAbort = 1'b1; iFillStart = 1'b1;
    step();
    iFillAbort = 1'b0; iFillStart = 1'b0;
    check_val("ab_we", oRamWe, 0);
    check_val("ab_busy", oFillBusy, 0);
    check_val("ab_done", oFillDone, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("ab_quiet_we%0d", i), oRamWe, 0);
      check_val($sformatf("ab_quiet_busy%0d", i), oFillBusy, 0);
    end
    set_rect(8'd7, 8'd7, 8'd2, 8'd2, 3'b101);
    start_fill();
    step();
    check_val("ab_restart_addr", oRamAddr, 16'h0207);
    check_val("ab_restart_we", oRamWe, 1);
    check_val("ab_restart_done", oFillDone, 1);
    step();

    // Reset mid-fill, then a fresh single-pixel fill
    set_rect(8'd0, 8'd3, 8'd0, 8'd1, 3'b110);
    start_fill();
    step(); step();
    Reset = 1'b0;
    step();
    check_val("mrst_we", oRamWe, 0);
    check_val("mrst_busy", oFillBusy, 0);
    check_val("mrst_done", oFillDone, 0);
    check_val("mrst_addr", oRamAddr, 0);
    check_val("mrst_data", oRamData, 0);
    Reset = 1'b1;
    step();
    check_val("mrst_rel_we", oRamWe, 0);
    set_rect(8'd0, 8'd0, 8'd0, 8'd0, 3'b001);
    start_fill();
    step();
    check_val("mrst_fill_we", oRamWe, 1);
    check_val("mrst_fill_addr", oRamAddr, 16'h0000);
    check_val("mrst_fill_done", oFillDone, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("mrst_quiet_we%0d", i), oRamWe, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
